fft_agu_issue: RTL and testbench

Address/twiddle issue unit for the radix-16, 65536-point FFT datapath. It sits upstream of the twiddle/address delay pipe and is the producer end of the BN/MA stream: it walks all 4 stages × 4096 butterfly groups. For each group it emits a conflict-free bank number (BN), a memory address (MA) and a base twiddle exponent. Output uses a valid/ready handshake so the butterfly side can stall it.

---
 rtl/fft_agu_pkg.sv | 36 +++
 rtl/fft_bank_map.sv | 14 +
 rtl/fft_agu.sv | 170 +++++++++++++++++
 tb/tb_fft_agu_issue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_agu_pkg.sv
// Shared widths, state encoding and twiddle helpers for the radix-16 FFT address/twiddle issue unit.
package fft_agu_pkg;

    localparam int A_WIDTH        = 11;
    localparam int G_WIDTH        = 12;
    localparam int E_WIDTH        = 12;
    localparam int N_STAGES       = 4;
    localparam int GROUPS         = 4096;
    localparam int GAP_CYCLES_DEF = 8;

    localparam logic [G_WIDTH-1:0] TW_MASK_S1  = 12'h0FF;
    localparam logic [G_WIDTH-1:0] TW_MASK_S2  = 12'h00F;
    localparam int                 TW_SHIFT_S1 = 4;
    localparam int                 TW_SHIFT_S2 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } agu_state_e;

    // Later stages keep fewer low digits of j and scale them up a digit per stage.
    function automatic logic [E_WIDTH-1:0] twExp(input logic [1:0] stg, input logic [G_WIDTH-1:0] j);
        logic [G_WIDTH-1:0] t;
        t = '0;
        case (stg)
            2'd0:    t = j;
            2'd1:    t = (j & TW_MASK_S1) << TW_SHIFT_S1;
            2'd2:    t = (j & TW_MASK_S2) << TW_SHIFT_S2;
            default: t = '0;
        endcase
        return E_WIDTH'(t);
    endfunction

endpackage

// File: rtl/fft_bank_map.sv
// Conflict-free bank/address mapping for a 3-hex-digit butterfly group index.
module fft_bank_map
    import fft_agu_pkg::*;
(
    input  logic [G_WIDTH-1:0] j_i,
    output logic               bn_o,
    output logic [A_WIDTH-1:0] ma_o
);

    // Parity of the digit sum only depends on each digit's LSB.
    assign bn_o = j_i[8] ^ j_i[4] ^ j_i[0];
    assign ma_o = j_i[G_WIDTH-1:1];

endmodule

// File: rtl/fft_agu.sv
// fft_agu_issue: walks 4 stages x 4096 groups, issuing BN/MA/tw_exp beats on a valid/ready stream.
// Define AGU_STAGE_GAP_EN to insert GAP_CYCLES idle cycles between stages.
module fft_agu_issue
    import fft_agu_pkg::*;
`ifdef AGU_STAGE_GAP_EN
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ready,
    output logic               valid,
    output logic               BN,
    output logic [A_WIDTH-1:0] MA,
    output logic [E_WIDTH-1:0] tw_exp,
    output logic [1:0]         stage,
    output logic               last,
    output logic               busy,
    output logic               done
);

    agu_state_e         state_q, state_d;
    logic [G_WIDTH-1:0] j_q, j_d;
    logic [1:0]         stg_q, stg_d;
    logic               accept;

    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bn_q, bn_d;
    logic [A_WIDTH-1:0] ma_q, ma_d;
    logic [E_WIDTH-1:0] tw_q, tw_d;
    logic [1:0]         stageOut_q, stageOut_d;
    logic               last_q, last_d;

    logic               bnNext;
    logic [A_WIDTH-1:0] maNext;

`ifdef AGU_STAGE_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] gapCnt_q, gapCnt_d;
`endif

    assign accept = valid_q & ready;

    fft_bank_map uMap (
        .j_i  (j_d),
        .bn_o (bnNext),
        .ma_o (maNext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            stg_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bn_q       <= 1'b0;
            ma_q       <= '0;
            tw_q       <= '0;
            stageOut_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            stg_q      <= stg_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bn_q       <= bn_d;
            ma_q       <= ma_d;
            tw_q       <= tw_d;
            stageOut_q <= stageOut_d;
            last_q     <= last_d;
        end
    end

`ifdef AGU_STAGE_GAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gapCnt_q <= '0;
        end else begin
            gapCnt_q <= gapCnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        stg_d   = stg_q;
`ifdef AGU_STAGE_GAP_EN
        gapCnt_d = gapCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = '0;
                    stg_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (j_q != G_WIDTH'(GROUPS - 1)) begin
                        j_d = j_q + G_WIDTH'(1);
                    end else if (stg_q != 2'(N_STAGES - 1)) begin
                        j_d   = '0;
                        stg_d = stg_q + 2'd1;
`ifdef AGU_STAGE_GAP_EN
                        state_d  = GAP;
                        gapCnt_d = '0;
`else
                        state_d = RUN;
`endif
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            GAP: begin
`ifdef AGU_STAGE_GAP_EN
                if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers load from the next beat so they change only on acceptance or a new stage.
    always_comb begin
        valid_d    = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == GAP);
        done_d     = (state_d == FIN);
        bn_d       = bn_q;
        ma_d       = ma_q;
        tw_d       = tw_q;
        stageOut_d = stageOut_q;
        last_d     = last_q;
        if (state_d == RUN) begin
            bn_d       = bnNext;
            ma_d       = maNext;
            tw_d       = twExp(stg_d, j_d);
            stageOut_d = stg_d;
            last_d     = (stg_d == 2'(N_STAGES - 1)) && (j_d == G_WIDTH'(GROUPS - 1));
        end
    end

    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign BN     = bn_q;
    assign MA     = ma_q;
    assign tw_exp = tw_q;
    assign stage  = stageOut_q;
    assign last   = last_q;

endmodule

// File: tb/tb_fft_agu_issue.sv
// Self-checking bench for fft_agu_issue: scoreboard of every beat, mapping table, backpressure and abort sequences.
module tb_fft_agu_issue;
    import fft_agu_pkg::*;

    localparam int NBEATS = 16384;
`ifdef AGU_STAGE_GAP_EN
    localparam int GAP_N = 8;
`else
    localparam int GAP_N = 0;
`endif
    localparam int DONE_AT = NBEATS + 1 + 3 * GAP_N;

    logic               clk = 1'b0;
    logic               rst, start, ready;
    logic               valid, BN, last, busy, done;
    logic [A_WIDTH-1:0] MA;
    logic [E_WIDTH-1:0] tw_exp;
    logic [1:0]         stage;

    typedef struct packed {
        logic [1:0]         stg;
        logic               bn;
        logic [A_WIDTH-1:0] ma;
        logic [E_WIDTH-1:0] tw;
        logic               lst;
    } beat_t;

    typedef struct {
        int                 s;
        int                 j;
        logic               bn;
        logic [A_WIDTH-1:0] ma;
        logic [E_WIDTH-1:0] tw;
        logic               lst;
    } vec_t;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t obsStore[NBEATS];
    vec_t  vecs[11];

    fft_agu_issue dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .valid  (valid),
        .BN     (BN),
        .MA     (MA),
        .tw_exp (tw_exp),
        .stage  (stage),
        .last   (last),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference beat built from the digit-sum definition rather than bit picks.
    function automatic beat_t modelBeat(input int s, input int j);
        beat_t b;
        int d0, d1, d2;
        d0 = j % 16;
        d1 = (j / 16) % 16;
        d2 = j / 256;
        b.stg = 2'(s);
        b.bn  = 1'((d0 + d1 + d2) % 2);
        b.ma  = A_WIDTH'(j / 2);
        case (s)
            0:       b.tw = E_WIDTH'(j);
            1:       b.tw = E_WIDTH'((j % 256) * 16);
            2:       b.tw = E_WIDTH'((j % 16) * 256);
            default: b.tw = '0;
        endcase
        b.lst = (s == 3) && (j == 4095);
        return b;
    endfunction

    function automatic beat_t curBeat();
        return beat_t'({stage, BN, MA, tw_exp, last});
    endfunction

    task automatic applyStimulus(input int lowPct, input int abortAt, input bit pokeStart, input bit record);
        beat_t      expq[$];
        beat_t      b, snap, e;
        bit         stalled, doneSeen, aborted;
        int         n, accepted, lastAccN, doneN;
        logic [1:0] prevStage;
        stalled   = 1'b0;
        doneSeen  = 1'b0;
        aborted   = 1'b0;
        n         = 1;
        accepted  = 0;
        lastAccN  = 0;
        doneN     = 0;
        prevStage = '0;
        snap      = '0;
        for (int s = 0; s < N_STAGES; s++)
            for (int j = 0; j < GROUPS; j++)
                expq.push_back(modelBeat(s, j));
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", {busy, valid}, 2'b11);
        while (!doneSeen && !aborted && n < 60000) begin
            b = curBeat();
            if (stalled) checkOutput("stall_hold", {valid, b}, {1'b1, snap});
            if (done) begin
                doneSeen = 1'b1;
                doneN    = n;
            end else begin
                if (valid && !stalled && accepted > 0 && b.stg != prevStage)
                    checkOutput("stage_gap", n - lastAccN - 1, GAP_N);
                start = pokeStart && (accepted == 100);
                ready = ($urandom_range(99) >= lowPct);
                if (valid && ready) begin
                    e = (expq.size() > 0) ? expq.pop_front() : '1;
                    checkOutput($sformatf("beat_%0d", accepted), b, e);
                    if (record && accepted < NBEATS) obsStore[accepted] = b;
                    prevStage = b.stg;
                    lastAccN  = n;
                    accepted++;
                    stalled   = 1'b0;
                    if (abortAt > 0 && accepted == abortAt) begin
                        #2 rst = 1'b1;
                        #1 checkOutput("abort_zero", {valid, curBeat(), busy, done}, '0);
                        for (int k = 0; k < 20; k++) begin
                            @(negedge clk);
                            if (k == 10) rst = 1'b0;
                            checkOutput("abort_no_done", {valid, busy, done}, 3'b000);
                        end
                        aborted = 1'b1;
                    end
                end else begin
                    stalled = valid;
                    snap    = b;
                end
            end
            if (!doneSeen && !aborted) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        if (!aborted) begin
            checkOutput("done_seen", doneSeen, 1'b1);
            checkOutput("beats_accepted", accepted, NBEATS);
            checkOutput("queue_empty", expq.size(), 0);
            checkOutput("busy_with_done", {busy, valid}, 2'b00);
            if (lowPct == 0) checkOutput("done_cycle", doneN, DONE_AT);
            @(negedge clk);
            checkOutput("done_pulse_idle", {done, busy, valid}, 3'b000);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 'h000, 1'b0, 'h000, 'h000, 1'b0};
        vecs[1]  = '{0, 'h001, 1'b1, 'h000, 'h001, 1'b0};
        vecs[2]  = '{0, 'h011, 1'b0, 'h008, 'h011, 1'b0};
        vecs[3]  = '{0, 'hFFF, 1'b1, 'h7FF, 'hFFF, 1'b0};
        vecs[4]  = '{0, 'h123, 1'b0, 'h091, 'h123, 1'b0};
        vecs[5]  = '{1, 'h123, 1'b0, 'h091, 'h230, 1'b0};
        vecs[6]  = '{2, 'h123, 1'b0, 'h091, 'h300, 1'b0};
        vecs[7]  = '{3, 'h123, 1'b0, 'h091, 'h000, 1'b0};
        vecs[8]  = '{1, 'hFFF, 1'b1, 'h7FF, 'hFF0, 1'b0};
        vecs[9]  = '{2, 'hFFF, 1'b1, 'h7FF, 'hF00, 1'b0};
        vecs[10] = '{3, 'hFFF, 1'b1, 'h7FF, 'h000, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_assert", {valid, BN, MA, tw_exp, stage, last, busy, done}, '0);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checkOutput("reset_idle", {valid, BN, MA, tw_exp, stage, last, busy, done}, '0);
        end

        $display("[TB] full-throughput run with start poked mid-run");
        applyStimulus(0, 0, 1'b1, 1'b1);
        for (int v = 0; v < 11; v++) begin
            beat_t expB;
            expB = '{stg: 2'(vecs[v].s), bn: vecs[v].bn, ma: vecs[v].ma, tw: vecs[v].tw, lst: vecs[v].lst};
            checkOutput($sformatf("vec_s%0d_j%03h", vecs[v].s, vecs[v].j),
                        obsStore[vecs[v].s * GROUPS + vecs[v].j], expB);
        end

        $display("[TB] abort at beat 5000");
        applyStimulus(0, 5000, 1'b0, 1'b0);

        $display("[TB] restart with 30%% backpressure");
        applyStimulus(30, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
